// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared snake-game definitions. Provides the 2-bit direction
//                encoding, the opposite-direction helper and the default
//                turn-FIFO depth. The body/collision logic uses it as well.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_DOWN  = 2'b01;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    localparam int DEFAULT_DEPTH = 4;

    // UP<->DOWN and LEFT<->RIGHT differ only in bit 0.
    function automatic dir_t opposite_dir(input dir_t d);
        return d ^ 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_dir_ctrl_if
//  Description : Signal bundle between the keyboard/game-timer side and the
//                direction controller.
//                master : drives up/down/left/right/tick/clear,
//                         observes dir/dir_chg/pending/overflow
//                slave  : the controller (opposite directions)
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_dir_ctrl_if
    import snake_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    logic                     up;
    logic                     down;
    logic                     left;
    logic                     right;
    logic                     tick;
    logic                     clear;
    dir_t                     dir;
    logic                     dir_chg;
    logic [$clog2(DEPTH):0]   pending;
    logic                     overflow;

    modport master (
        output up, down, left, right, tick, clear,
        input  dir, dir_chg, pending, overflow
    );

    modport slave (
        input  up, down, left, right, tick, clear,
        output dir, dir_chg, pending, overflow
    );
endinterface
`default_nettype wire

// File: rtl/snake_dir_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : snake_dir_fifo
//  Description : DEPTH x 2-bit synchronous FIFO for buffered turn requests.
//                Ports: clk, rst (async, active-high), push/wdata, pop/rdata
//                (rdata shows the head, valid when not empty), flush
//                (synchronous empty), count, full, empty.
//                Simultaneous push and pop while full is permitted: the head
//                is read before its slot is overwritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire dir_t                   wdata,
    input  wire logic                   pop,
    input  wire logic                   flush,
    output dir_t                        rdata,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dir_t             mem_q [DEPTH];
    dir_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are power-of-two wide, so +1 wraps modulo DEPTH.
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DIR_UP;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snake_dir_ctrl
//  Description : Snake direction controller. Turns held arrow-key levels into
//                one-shot turn requests, rejects repeats and 180-degree
//                reversals, queues legal turns and applies one per game tick.
//                Ports: clk, rst (async, active-high), bus (slave modport):
//                  up/down/left/right - key-held levels
//                  tick               - one-cycle game-step pulse
//                  clear              - synchronous new-game restart
//                  dir                - current direction
//                  dir_chg            - pulse, dir changed on preceding tick
//                  pending            - number of queued turns
//                  overflow           - sticky, a legal turn was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int   DEPTH    = DEFAULT_DEPTH,
    parameter dir_t INIT_DIR = DIR_RIGHT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    snake_dir_ctrl_if.slave  bus
);
    // Key vector ordering is also the priority order: UP, DOWN, LEFT, RIGHT.
    logic [3:0] keys;
    logic [3:0] prev_q, prev_d;
    logic [3:0] press;

    dir_t dir_q,      dir_d;
    dir_t ref_dir_q,  ref_dir_d;
    logic dir_chg_q,  dir_chg_d;
    logic overflow_q, overflow_d;

    logic ev_valid;
    dir_t ev_code;
    logic ev_legal;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    dir_t fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;

    assign keys  = {bus.up, bus.down, bus.left, bus.right};
    assign press = keys & ~prev_q;

    always_comb begin
        ev_valid = |press;
        ev_code  = DIR_RIGHT;
        if (press[3]) begin
            ev_code = DIR_UP;
        end else if (press[2]) begin
            ev_code = DIR_DOWN;
        end else if (press[1]) begin
            ev_code = DIR_LEFT;
        end
    end

    // Legality is judged against the last accepted turn, not the current
    // dir, so a queued sequence cannot contain a reversal.
    assign ev_legal = ev_valid && (ev_code != ref_dir_q)
                               && (ev_code != opposite_dir(ref_dir_q));

    // A full queue still accepts a turn when the same tick frees a slot.
    assign fifo_push = !bus.clear && ev_legal && (!fifo_full || bus.tick);
    assign fifo_pop  = !bus.clear && bus.tick && !fifo_empty;

    always_comb begin
        prev_d     = keys;
        dir_d      = dir_q;
        ref_dir_d  = ref_dir_q;
        dir_chg_d  = 1'b0;
        overflow_d = overflow_q;
        if (bus.clear) begin
            dir_d      = INIT_DIR;
            ref_dir_d  = INIT_DIR;
            overflow_d = 1'b0;
        end else begin
            if (fifo_pop) begin
                dir_d     = fifo_head;
                dir_chg_d = 1'b1;
            end
            if (fifo_push) begin
                ref_dir_d = ev_code;
            end else if (ev_legal) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            dir_q      <= INIT_DIR;
            ref_dir_q  <= INIT_DIR;
            dir_chg_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            dir_q      <= dir_d;
            ref_dir_q  <= ref_dir_d;
            dir_chg_q  <= dir_chg_d;
            overflow_q <= overflow_d;
        end
    end

    snake_dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (ev_code),
        .pop   (fifo_pop),
        .flush (bus.clear),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.dir      = dir_q;
    assign bus.dir_chg  = dir_chg_q;
    assign bus.pending  = fifo_count;
    assign bus.overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_dir_ctrl
//  Description : Self-checking bench for snake_dir_ctrl. Expected directions
//                are queued as turns are pressed and compared whenever the
//                DUT pulses dir_chg; status outputs are checked directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_dir_ctrl;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    snake_dir_ctrl_if #(.DEPTH(4)) bus ();

    snake_dir_ctrl #(
        .DEPTH    (4),
        .INIT_DIR (2'b11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q [$];
    logic [1:0] sb_exp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every dir_chg pulse must match the next queued turn.
    always @(negedge clk) begin
        if (!rst && bus.dir_chg === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("dir_chg_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                check_val("dir_scoreboard", {30'd0, bus.dir}, {30'd0, sb_exp});
            end
        end
    end

    task automatic set_keys(input logic [3:0] k);
        bus.up    = k[3];
        bus.down  = k[2];
        bus.left  = k[1];
        bus.right = k[0];
    endtask

    task automatic press(input logic [3:0] k);
        set_keys(k);
        @(negedge clk);
        set_keys(4'b0000);
        @(negedge clk);
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        check_val("clear_dir", {30'd0, bus.dir}, 32'd3);
        check_val("clear_pending", {29'd0, bus.pending}, 32'd0);
        check_val("clear_overflow", {31'd0, bus.overflow}, 32'd0);
    endtask

    initial begin
        set_keys(4'b0000);
        bus.tick  = 1'b0;
        bus.clear = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_val("rst_dir", {30'd0, bus.dir}, 32'd3);
        check_val("rst_pending", {29'd0, bus.pending}, 32'd0);
        check_val("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check_val("rst_dir_chg", {31'd0, bus.dir_chg}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Press UP then tick: dir becomes UP, dir_chg pulses exactly once
        exp_q.push_back(DIR_UP);
        press(4'b1000);
        check_val("up_pending", {29'd0, bus.pending}, 32'd1);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        check_val("up_dir_chg_hi", {31'd0, bus.dir_chg}, 32'd1);
        check_val("up_dir", {30'd0, bus.dir}, 32'd0);
        @(negedge clk);
        check_val("up_dir_chg_lo", {31'd0, bus.dir_chg}, 32'd0);

        // Holding a key yields one event at most
        set_keys(4'b1000);
        repeat (50) @(negedge clk);
        check_val("hold_up_pending", {29'd0, bus.pending}, 32'd0);
        set_keys(4'b0000);
        @(negedge clk);
        exp_q.push_back(DIR_LEFT);
        set_keys(4'b0010);
        repeat (50) @(negedge clk);
        check_val("hold_left_pending", {29'd0, bus.pending}, 32'd1);
        set_keys(4'b0000);
        @(negedge clk);
        tick_once();
        do_clear();

        // Reversal from RIGHT is rejected
        press(4'b0010);
        check_val("rev_pending", {29'd0, bus.pending}, 32'd0);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        check_val("rev_dir", {30'd0, bus.dir}, 32'd3);
        check_val("rev_no_chg", {31'd0, bus.dir_chg}, 32'd0);
        // DOWN then LEFT: both legal in sequence
        exp_q.push_back(DIR_DOWN);
        exp_q.push_back(DIR_LEFT);
        press(4'b0100);
        press(4'b0010);
        check_val("seq_pending", {29'd0, bus.pending}, 32'd2);
        tick_once();
        tick_once();
        check_val("seq_dir", {30'd0, bus.dir}, 32'd2);
        do_clear();

        // UP and LEFT together: UP wins
        exp_q.push_back(DIR_UP);
        press(4'b1010);
        check_val("simul_pending", {29'd0, bus.pending}, 32'd1);
        tick_once();
        check_val("simul_dir", {30'd0, bus.dir}, 32'd0);
        do_clear();

        // Overflow: fifth legal turn with no tick is dropped
        exp_q.push_back(DIR_UP);
        exp_q.push_back(DIR_LEFT);
        exp_q.push_back(DIR_DOWN);
        exp_q.push_back(DIR_RIGHT);
        press(4'b1000);
        press(4'b0010);
        press(4'b0100);
        press(4'b0001);
        check_val("ovf_pre_flag", {31'd0, bus.overflow}, 32'd0);
        press(4'b1000);
        check_val("ovf_pending", {29'd0, bus.pending}, 32'd4);
        check_val("ovf_flag", {31'd0, bus.overflow}, 32'd1);
        repeat (4) tick_once();
        check_val("ovf_drain_pending", {29'd0, bus.pending}, 32'd0);
        check_val("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        do_clear();

        // Full queue plus tick plus legal press
        exp_q.push_back(DIR_UP);
        exp_q.push_back(DIR_LEFT);
        exp_q.push_back(DIR_DOWN);
        exp_q.push_back(DIR_RIGHT);
        exp_q.push_back(DIR_UP);
        press(4'b1000);
        press(4'b0010);
        press(4'b0100);
        press(4'b0001);
        set_keys(4'b1000);
        bus.tick = 1'b1;
        @(negedge clk);
        set_keys(4'b0000);
        bus.tick = 1'b0;
        check_val("fulltick_pending", {29'd0, bus.pending}, 32'd4);
        check_val("fulltick_overflow", {31'd0, bus.overflow}, 32'd0);
        check_val("fulltick_dir", {30'd0, bus.dir}, 32'd0);
        @(negedge clk);
        repeat (4) tick_once();
        check_val("fulltick_drain", {29'd0, bus.pending}, 32'd0);
        do_clear();

        // clear together with tick, three turns queued
        press(4'b1000);
        press(4'b0010);
        press(4'b0100);
        check_val("clr3_pending_pre", {29'd0, bus.pending}, 32'd3);
        bus.clear = 1'b1;
        bus.tick  = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        bus.tick  = 1'b0;
        check_val("clr3_pending", {29'd0, bus.pending}, 32'd0);
        check_val("clr3_dir", {30'd0, bus.dir}, 32'd3);
        check_val("clr3_dir_chg", {31'd0, bus.dir_chg}, 32'd0);
        @(negedge clk);
        check_val("clr3_dir_chg2", {31'd0, bus.dir_chg}, 32'd0);

        // Asynchronous reset mid-queue with dir_chg and overflow set
        exp_q.push_back(DIR_UP);
        press(4'b1000);
        press(4'b0010);
        press(4'b0100);
        press(4'b0001);
        press(4'b1000);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_dir", {30'd0, bus.dir}, 32'd3);
        check_val("arst_pending", {29'd0, bus.pending}, 32'd0);
        check_val("arst_overflow", {31'd0, bus.overflow}, 32'd0);
        check_val("arst_dir_chg", {31'd0, bus.dir_chg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_val("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

Direction controller for the snake game, sitting directly downstream of the PS/2 keyboard decoder. It converts the decoder's level-held arrow-key flags (up/left/right/down) into one-shot turn requests. It filters illegal turns (repeat, 180° reversal) and buffers legal turns in a small FIFO. On each game-step tick it applies one buffered turn, so quick key sequences between two ticks are not lost.

## Interface
Parameters:
- DEPTH, 4, turn-request FIFO entries (power of two, 2..16)
- INIT_DIR, 2'b11, direction after reset/clear (RIGHT)

Ports:
- clk  input  1  system clock, same domain as PS/2 decoder outputs
- rst  input  1  asynchronous, active-high reset
- up, down, left, right  input  1 each  key-held levels from decoder (1 = pressed)
- tick  input  1  one-cycle game-step pulse from the game timer
- clear  input  1  synchronous restart (new game)
- dir  output  2  current movement direction: 00 UP, 01 DOWN, 10 LEFT, 11 RIGHT
- dir_chg  output  1  one-cycle pulse: dir changed on the preceding tick
- pending  output  $clog2(DEPTH)+1  number of buffered turns
- overflow  output  1  sticky: a legal turn was dropped because the FIFO was full

## Operation
- Edge detect: per key, register previous level; press event = level & ~prev. Held keys generate exactly one event.
- Simultaneous press events in one cycle: only the highest-priority event is taken (UP > DOWN > LEFT > RIGHT); the others are discarded.
- ref_dir register = last accepted direction (FIFO tail if non-empty, else dir). An event is legal iff code != ref_dir and code != opposite(ref_dir); opposite = code ^ 2'b01.
- Legal event: if pending < DEPTH, or pending == DEPTH with tick this cycle, push code and set ref_dir <= code. Otherwise drop and set overflow <= 1.
- Illegal event: dropped silently; overflow unaffected.
- tick with pending > 0 (value before the cycle): pop head, dir <= head, dir_chg <= 1 next cycle. tick with pending == 0: no change, dir_chg stays 0.
- clear: flush FIFO (pending <= 0), dir <= INIT_DIR, ref_dir <= INIT_DIR, overflow <= 0, dir_chg <= 0. Overrides tick and any event in the same cycle. The prev-key registers still update, so a key held through clear does not re-fire.
- Reset values: dir = INIT_DIR, ref_dir = INIT_DIR, pending = 0, overflow = 0, dir_chg = 0, prev-key registers = 0.

## Timing
- Press event sampled at posedge n: pending increments after posedge n. The entry is eligible for a tick at posedge n+1 or later.
- Tick and push in the same cycle with pending == 0: tick has nothing to pop. The entry remains and pending = 1.
- Tick and push with pending == DEPTH: pop and push both occur, pending stays DEPTH, and overflow is not set.
- dir updates on the posedge that samples tick. dir_chg is high for exactly the following cycle.
- Pointer wrap-around modulo DEPTH. pending never exceeds DEPTH.
- rst is asynchronous mid-operation: all state returns immediately to reset values. clear applies on the next posedge.

## Structure
- Shared package snake_pkg holds: DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 2-bit constants, the opposite-direction function, default DEPTH. The snake body/collision logic reuses these.
- One sub-module: snake_dir_fifo (parameterised DEPTH × 2-bit synchronous FIFO with push, pop, flush, count, full and empty). Edge detect, priority select, legality check and dir register live in the top module.

## Test plan
- Reset: dir = 11, pending = 0, overflow = 0. Press UP, then tick: dir = 00, dir_chg pulses once. Hold UP for 50 cycles: pending stays 0.
- Reversal: dir = RIGHT, press LEFT, then tick: dir stays 11, pending = 0. Press DOWN, press LEFT, tick, tick: dir sequence 01 then 10.
- Simultaneous keys: UP and LEFT rise in the same cycle with dir = RIGHT: pending = 1. After tick, dir = 00.
- Overflow (DEPTH = 4, dir = RIGHT): press UP, LEFT, DOWN, RIGHT, UP with no tick: first four accepted, fifth dropped, overflow = 1, pending = 4. Ticks yield 00, 10, 01, 11.
- Full plus tick: pending = 4, a legal press coincides with tick: pending stays 4, overflow stays 0, and the popped head appears on dir.
- Clear and rst: with pending = 3 assert clear together with tick: pending = 0, dir = INIT_DIR, no dir_chg. Assert rst asynchronously mid-queue: outputs return to reset values before the next clk edge.
